// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : EX-stage HI/LO unit. It provides an iterative or single-stage
//               multiply, an optional restoring divider (EX_DIV_EN) and the
//               MFHI/MTHI/MFLO/MTLO moves.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush_in,
  input  logic [7:0]        aluop_in,
  input  logic [DATA_W-1:0] reg1_in,
  input  logic [DATA_W-1:0] reg2_in,
  input  logic [4:0]        wd_in,
  input  logic              wreg_in,
  output logic [4:0]        wd_out,
  output logic              wreg_out,
  output logic [DATA_W-1:0] wdata_out,
  output logic              stall_req_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              done_out,
  output logic              div_zero_out
);
  localparam logic [7:0] C_OP_MULT  = 8'b00011000;
  localparam logic [7:0] C_OP_MULTU = 8'b00011001;
  localparam logic [7:0] C_OP_DIV   = 8'b00011010;
  localparam logic [7:0] C_OP_MFHI  = 8'b00010000;
  localparam logic [7:0] C_OP_MTHI  = 8'b00010001;
  localparam logic [7:0] C_OP_MFLO  = 8'b00010010;
  localparam logic [7:0] C_OP_MTLO  = 8'b00010011;
  localparam int         C_CNT_W    = $clog2(DATA_W);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [C_CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]     r_hi, r_lo;
  logic                  r_neg_q;
  logic [2*DATA_W-1:0]   r_acc, r_mcand;
  logic [DATA_W-1:0]     r_mplier;

  logic                  w_is_mul, w_is_div, w_is_signed, w_accept, w_div_zero;
  logic                  w_a_neg, w_b_neg, w_wr_mul, w_wr_div;
  logic [DATA_W-1:0]     w_a_mag, w_b_mag, w_div_hi, w_div_lo;
  logic [2*DATA_W-1:0]   w_mul_step, w_mul_res;

  assign w_is_mul    = (aluop_in == C_OP_MULT) || (aluop_in == C_OP_MULTU);
  assign w_is_signed = (aluop_in == C_OP_MULT) || (aluop_in == C_OP_DIV);
  assign w_a_neg     = w_is_signed && reg1_in[DATA_W-1];
  assign w_b_neg     = w_is_signed && reg2_in[DATA_W-1];
  assign w_a_mag     = w_a_neg ? -reg1_in : reg1_in;
  assign w_b_mag     = w_b_neg ? -reg2_in : reg2_in;
  assign w_accept    = (r_state == S_IDLE) && valid_in && !flush_in && (w_is_mul || w_is_div);

  // One partial product per cycle; the sign is applied to the last sum only.
  assign w_mul_step  = r_acc + (r_mplier[0] ? r_mcand : '0);

  generate
    if (MUL_ITER == 0) begin : g_mul_comb
      logic [2*DATA_W-1:0] w_prod;
      assign w_prod    = {{DATA_W{1'b0}}, w_a_mag} * {{DATA_W{1'b0}}, w_b_mag};
      assign w_mul_res = (w_a_neg ^ w_b_neg) ? -w_prod : w_prod;
    end else begin : g_mul_iter
      assign w_mul_res = r_neg_q ? -w_mul_step : w_mul_step;
    end
  endgenerate

`ifdef EX_DIV_EN
  localparam logic [7:0] C_OP_DIVU = 8'b00011011;
  logic              r_dz, r_neg_r;
  logic [DATA_W:0]   r_rem;
  logic [DATA_W-1:0] r_quo, r_dvsr;
  logic [DATA_W:0]   w_shift, w_diff, w_rem_n;
  logic [DATA_W-1:0] w_quo_n;
  logic              w_ge;

  assign w_is_div   = (aluop_in == C_OP_DIV) || (aluop_in == C_OP_DIVU);
  assign w_div_zero = (reg2_in == '0);
  // Restoring step: the dividend shifts out of r_quo as quotient bits shift in.
  assign w_shift    = {r_rem[DATA_W-1:0], r_quo[DATA_W-1]};
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign w_ge       = !w_diff[DATA_W];
  assign w_rem_n    = w_ge ? w_diff : w_shift;
  assign w_quo_n    = {r_quo[DATA_W-2:0], w_ge};
  assign w_div_lo   = r_neg_q ? -w_quo_n : w_quo_n;
  assign w_div_hi   = r_neg_r ? -w_rem_n[DATA_W-1:0] : w_rem_n[DATA_W-1:0];
  assign div_zero_out = (r_state == S_DONE) && r_dz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dz    <= 1'b0;
      r_neg_r <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
    end else begin
      if (w_accept) r_dz <= w_is_div && w_div_zero;
      if (w_accept && w_is_div) begin
        r_neg_r <= w_a_neg;
        r_rem   <= '0;
        r_quo   <= w_a_mag;
        r_dvsr  <= w_b_mag;
      end else if (r_state == S_DIV) begin
        r_rem   <= w_rem_n;
        r_quo   <= w_quo_n;
      end
    end
  end
`else
  assign w_is_div     = 1'b0;
  assign w_div_zero   = 1'b0;
  assign w_div_hi     = '0;
  assign w_div_lo     = '0;
  assign div_zero_out = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    stall_req_out = 1'b0;
    done_out      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (valid_in && w_is_mul) begin
          stall_req_out = 1'b1;
          w_state_nxt   = (MUL_ITER == 0) ? S_DONE : S_MUL;
        end else if (valid_in && w_is_div) begin
          stall_req_out = 1'b1;
          w_state_nxt   = w_div_zero ? S_DONE : S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        stall_req_out = 1'b1;
        if (r_cnt == C_CNT_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_out    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
    if (flush_in) w_state_nxt = S_IDLE;
    if (rst) stall_req_out = 1'b0;
  end

  // Results land on the edge into DONE; a flush diverts that edge to IDLE.
  assign w_wr_mul = (w_state_nxt == S_DONE) &&
                    ((r_state == S_MUL) || ((r_state == S_IDLE) && w_is_mul));
  assign w_wr_div = (w_state_nxt == S_DONE) && (r_state == S_DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= ((r_state == S_MUL || r_state == S_DIV) && w_state_nxt == r_state) ?
                 r_cnt + C_CNT_W'(1) : '0;
      if (w_accept) begin
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_acc    <= '0;
        r_mcand  <= {{DATA_W{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
      end else if (r_state == S_MUL) begin
        r_acc    <= w_mul_step;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (r_state == S_IDLE && valid_in && !flush_in) begin
        if (aluop_in == C_OP_MTHI) r_hi <= reg1_in;
        if (aluop_in == C_OP_MTLO) r_lo <= reg1_in;
      end
      if (w_wr_mul) begin
        r_hi <= w_mul_res[2*DATA_W-1:DATA_W];
        r_lo <= w_mul_res[DATA_W-1:0];
      end else if (w_wr_div) begin
        r_hi <= w_div_hi;
        r_lo <= w_div_lo;
      end
    end
  end

  assign hi_out    = r_hi;
  assign lo_out    = r_lo;
  assign wd_out    = rst ? 5'd0 : wd_in;
  assign wreg_out  = !rst && wreg_in && ((aluop_in == C_OP_MFHI) || (aluop_in == C_OP_MFLO));
  assign wdata_out = rst                     ? '0   :
                     (aluop_in == C_OP_MFHI) ? r_hi :
                     (aluop_in == C_OP_MFLO) ? r_lo : '0;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Scoreboard bench for ex_muldiv against a plain-arithmetic
//               HI/LO reference model (DATA_W=32, MUL_ITER=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
  localparam int W = 32;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [7:0] OP_MFHI  = 8'b00010000;
  localparam logic [7:0] OP_MTHI  = 8'b00010001;
  localparam logic [7:0] OP_MFLO  = 8'b00010010;
  localparam logic [7:0] OP_MTLO  = 8'b00010011;
  localparam logic [7:0] OP_NOP   = 8'b00100000;
`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b1, valid_in = 1'b0, flush_in = 1'b0, wreg_in = 1'b0;
  logic [7:0]   aluop_in = OP_NOP;
  logic [W-1:0] reg1_in = '0, reg2_in = '0;
  logic [4:0]   wd_in = '0;
  logic [4:0]   wd_out;
  logic         wreg_out, stall_req_out, done_out, div_zero_out;
  logic [W-1:0] wdata_out, hi_out, lo_out;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int           n_total = 0, n_bad = 0;
  logic [7:0]   md_ops[4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};

  ex_muldiv #(.DATA_W(W), .MUL_ITER(1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush_in(flush_in),
    .aluop_in(aluop_in), .reg1_in(reg1_in), .reg2_in(reg2_in),
    .wd_in(wd_in), .wreg_in(wreg_in), .wd_out(wd_out), .wreg_out(wreg_out),
    .wdata_out(wdata_out), .stall_req_out(stall_req_out), .hi_out(hi_out),
    .lo_out(lo_out), .done_out(done_out), .div_zero_out(div_zero_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] mul_ref(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = a;
    ub = b;
    return ua * ub;
  endfunction

  // Returns {remainder, quotient}; operands are widened so MIN/-1 cannot trap.
  function automatic logic [63:0] div_ref(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa, sb, q, r;
    logic [W-1:0] uq, ur;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[W-1:0], q[W-1:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done_out) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_hi", hi_out, e.hi);
        chk("done_lo", lo_out, e.lo);
        chk("done_divzero", div_zero_out, e.dz);
      end
    end
  end

  task automatic run_op(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int          exp_stall, cnt;
    bit          is_mul, is_div, sgn;
    logic [63:0] p;
    exp_t        e;
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = DIV_EN && ((op == OP_DIV) || (op == OP_DIVU));
    sgn       = (op == OP_MULT) || (op == OP_DIV);
    exp_stall = 0;
    if (is_mul || (is_div && b != '0)) begin
      p = is_mul ? mul_ref(sgn, a, b) : div_ref(sgn, a, b);
      m_hi = p[63:32];
      m_lo = p[31:0];
      exp_stall = W + 1;
    end else if (is_div) begin
      exp_stall = 1;
    end
    if (is_mul || is_div) begin
      e.hi = m_hi;
      e.lo = m_lo;
      e.dz = is_div && (b == '0);
      exp_q.push_back(e);
    end
    @(negedge clk);
    valid_in = 1'b1; aluop_in = op; reg1_in = a; reg2_in = b;
    #1 cnt = stall_req_out ? 1 : 0;
    @(negedge clk);
    valid_in = 1'b0; aluop_in = OP_NOP;
    #1;
    while (stall_req_out && cnt < 4 * W) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", cnt, exp_stall);
    chk("op_hi", hi_out, m_hi);
    chk("op_lo", lo_out, m_lo);
  endtask

  task automatic mt(input logic [7:0] op, input logic [W-1:0] v);
    @(negedge clk);
    valid_in = 1'b1; aluop_in = op; reg1_in = v; wreg_in = 1'b1;
    #1 chk("mt_wreg", wreg_out, 1'b0);
    if (op == OP_MTHI) m_hi = v; else m_lo = v;
    @(negedge clk);
    valid_in = 1'b0; aluop_in = OP_NOP; wreg_in = 1'b0;
    #1;
    chk("mt_hi", hi_out, m_hi);
    chk("mt_lo", lo_out, m_lo);
  endtask

  task automatic mf(input logic [7:0] op, input logic [4:0] wd);
    @(negedge clk);
    valid_in = 1'b1; aluop_in = op; wd_in = wd; wreg_in = 1'b1;
    #1;
    chk("mf_wdata", wdata_out, (op == OP_MFHI) ? m_hi : m_lo);
    chk("mf_wreg", wreg_out, 1'b1);
    chk("mf_wd", wd_out, wd);
    valid_in = 1'b0; aluop_in = OP_NOP; wreg_in = 1'b0;
  endtask

  // Start an op, then flush or reset it while the counter reads 10.
  task automatic abort_op(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit use_rst);
    @(negedge clk);
    valid_in = 1'b1; aluop_in = op; reg1_in = a; reg2_in = b;
    @(negedge clk);
    valid_in = 1'b0; aluop_in = OP_NOP;
    repeat (10) @(negedge clk);
    if (use_rst) begin
      rst = 1'b1; valid_in = 1'b1; aluop_in = OP_MFHI; wreg_in = 1'b1; wd_in = 5'd7;
      #1;
      chk("rst_stall", stall_req_out, 1'b0);
      chk("rst_wreg", wreg_out, 1'b0);
      chk("rst_wdata", wdata_out, '0);
      chk("rst_wd", wd_out, 5'd0);
      m_hi = '0;
      m_lo = '0;
    end else begin
      flush_in = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; flush_in = 1'b0; valid_in = 1'b0; aluop_in = OP_NOP; wreg_in = 1'b0;
    #1;
    chk("abort_stall", stall_req_out, 1'b0);
    chk("abort_hi", hi_out, m_hi);
    chk("abort_lo", lo_out, m_lo);
  endtask

  initial begin
    valid_in = 1'b1; aluop_in = OP_MFHI; wreg_in = 1'b1; wd_in = 5'd3;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_hi", hi_out, '0);
    chk("reset_lo", lo_out, '0);
    chk("reset_done", done_out, 1'b0);
    chk("reset_wreg", wreg_out, 1'b0);
    chk("reset_wd", wd_out, 5'd0);
    aluop_in = OP_MULT;
    #1 chk("reset_stall", stall_req_out, 1'b0);
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0; aluop_in = OP_NOP; wreg_in = 1'b0;

    mt(OP_MTHI, 32'h12345678);
    mf(OP_MFHI, 5'd5);
    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    run_op(OP_DIVU, 32'd100, 32'd0);
    run_op(OP_MULT, 32'hFFFFFFFE, 32'h00000003);
    mf(OP_MFLO, 5'd9);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    mf(OP_MFHI, 5'd31);
    run_op(OP_NOP, 32'hDEADBEEF, 32'h5);

    abort_op(DIV_EN ? OP_DIVU : OP_MULTU, 32'd100, 32'd7, 1'b0);
    abort_op(OP_MULTU, 32'd1234, 32'd5678, 1'b0);
    run_op(OP_MULTU, 32'd3, 32'd5);
    abort_op(DIV_EN ? OP_DIVU : OP_MULTU, 32'd100, 32'd7, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      int           sel;
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h80000000; b = '1; end
      else if (sel == 2) b = $urandom_range(1, 15);
      else if (sel == 3) a = $urandom_range(0, 1000);
      run_op(md_ops[$urandom_range(0, 3)], a, b);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter DATA_W, default 32, operand/HI/LO width; legal values 8..64, even.
REQ-002 Parameter MUL_ITER, default 1; 1 = iterative shift-add multiply, 0 = single-stage multiply.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 valid_in  in  1  instruction present in EX this cycle.
REQ-006 flush_in  in  1  cancel in-flight operation.
REQ-007 aluop_in  in  8  op subtype: MULT 00011000, MULTU 00011001, DIV 00011010, DIVU 00011011, MFHI 00010000, MTHI 00010001, MFLO 00010010, MTLO 00010011.
REQ-008 reg1_in / reg2_in  in  DATA_W  operand 1 (multiplicand/dividend) / operand 2 (multiplier/divisor).
REQ-009 wd_in  in  5; wreg_in  in  1  destination register address / write enable from decode.
REQ-010 wd_out  out  5; wreg_out  out  1; wdata_out  out  DATA_W  final destination address, enable, data.
REQ-011 stall_req_out  out  1  pipeline stall request.
REQ-012 hi_out / lo_out  out  DATA_W  current HI/LO contents.
REQ-013 done_out  out  1  one-cycle pulse, mul/div result committed.
REQ-014 div_zero_out  out  1  one-cycle pulse, divide by zero.

Function
REQ-015 FSM states IDLE, MUL, DIV, DONE; op accepted only when valid_in=1 in IDLE.
REQ-016 IDLE + MULT/MULTU -> MUL (MUL_ITER=1) or DONE (MUL_ITER=0); IDLE + DIV/DIVU -> DIV, or DONE if reg2_in=0.
REQ-017 Iterative MUL/DIV run exactly DATA_W cycles (counter 0..DATA_W-1), then -> DONE; DONE -> IDLE unconditionally, ignoring valid_in.
REQ-018 stall_req_out = (IDLE & valid_in & mul/div op) | MUL | DIV; low in DONE; iterative op stalls DATA_W+1 cycles.
REQ-019 Operands latched at acceptance; signed ops use magnitudes, sign fixed on final iteration.
REQ-020 Multiply: {HI,LO} = 2*DATA_W-bit product, signed (MULT) or unsigned (MULTU).
REQ-021 Divide: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
REQ-022 Signed most-negative / -1: LO = most-negative value, HI = 0, no flag.
REQ-023 Divide by zero: HI/LO unchanged; div_zero_out=1 and done_out=1 in the DONE cycle.
REQ-024 HI/LO written on the edge entering DONE; done_out=1 only while in DONE.
REQ-025 MTHI/MTLO: HI/LO <= reg1_in at the edge, IDLE & valid_in only; wreg_out=0.
REQ-026 MFHI/MFLO: wdata_out = HI/LO (combinational), wreg_out=wreg_in, wd_out=wd_in; value written in DONE visible next cycle.
REQ-027 MULT/MULTU/DIV/DIVU: wreg_out=0, wdata_out=0; all other aluop values: wreg_out=0, wdata_out=0, no state change.
REQ-028 flush_in=1 in any state: -> IDLE next edge, HI/LO unchanged, no done/div_zero pulse; flush wins over acceptance.

Reset
REQ-029 rst=1 at an edge: state IDLE, counter 0, HI=0, LO=0, done_out=0, div_zero_out=0, including mid-operation.
REQ-030 While rst=1: stall_req_out=0, wreg_out=0, wdata_out=0, wd_out=0.

Configuration
REQ-031 Macro EX_DIV_EN defined: divider compiled in, REQ-016..REQ-023 divide behaviour as stated.
REQ-032 EX_DIV_EN undefined: no divider logic; DIV/DIVU are NOPs -- no stall, HI/LO unchanged, div_zero_out tied 0.

Verification (DATA_W=32, MUL_ITER=1, EX_DIV_EN defined)
REQ-033 MULT 0xFFFFFFFE x 0x00000003 -> stall 33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA, one done_out pulse.
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 DIVU 100 / 0 with HI=0x11, LO=0x22 -> stall 1 cycle, div_zero_out=1, HI=0x11, LO=0x22.
REQ-037 DIVU 100/7 with flush_in at iteration 10 -> IDLE next cycle, stall low, HI/LO unchanged; rst at iteration 10 -> HI=LO=0.
REQ-038 MTHI 0x12345678, then MFHI wd_in=5 -> wdata_out=0x12345678, wreg_out=1, wd_out=5.
